// File: rtl/monitor_sched_pkg.sv
// Shared types and default constants for the monitor event scheduler.
package monitor_sched_pkg;

  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned DELTA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned MIN_GAP_DEF = 1;
  localparam int unsigned LATE_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_GAP
  } sched_state_t;

  // One queued event at the default widths: value plus wait count before issue.
  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] data;
    logic [DELTA_W_DEF-1:0]       delta;
  } sched_event_t;

endpackage

// File: rtl/monitor_event_scheduler_fifo.sv
// Synchronous FIFO for pending events; reset clears pointers and count, not storage.
module event_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/monitor_event_scheduler.sv
// Cycle-exact scheduler feeding timestamped events into the monitor's input_0/new_input_0 pair.
module monitor_event_scheduler
  import monitor_sched_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DELTA_W = DELTA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned MIN_GAP = MIN_GAP_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic signed [DATA_W-1:0]  ev_data,
  input  logic [DELTA_W-1:0]        ev_delta,
  output logic signed [DATA_W-1:0]  mon_input,
  output logic                      mon_new_input,
  input  logic                      mon_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy,
  output logic [LATE_W-1:0]         late_count
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = DATA_W + DELTA_W;
  localparam int unsigned GAP_W = $clog2(MIN_GAP + 2);

  sched_state_t             state_q, state_d;
  logic [DELTA_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     first_q, first_d;
  logic signed [DATA_W-1:0] mon_input_d;
  logic                     mon_new_input_d;
  logic [LATE_W-1:0]        late_d;

  logic                     push_c;
  logic                     pop_c;
  logic [EW-1:0]            head_c;
  logic signed [DATA_W-1:0] head_data_c;
  logic [DELTA_W-1:0]       head_delta_c;

  assign ev_ready     = en && (fifo_count < CW'(DEPTH));
  assign push_c       = ev_valid && ev_ready;
  assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);
  assign head_data_c  = head_c[EW-1:DELTA_W];
  assign head_delta_c = head_c[DELTA_W-1:0];

  event_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata ({ev_data, ev_delta}),
    .pop   (pop_c),
    .rdata (head_c),
    .count (fifo_count)
  );

  // Next-state and next-output logic; with en low every register holds.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    gap_d           = gap_q;
    data_d          = data_q;
    first_d         = first_q;
    mon_input_d     = mon_input;
    mon_new_input_d = mon_new_input;
    late_d          = late_count;
    pop_c           = 1'b0;
    if (en) begin
      first_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fifo_count != '0) begin
            pop_c  = 1'b1;
            data_d = head_data_c;
            cnt_d  = head_delta_c;
            if (head_delta_c == '0) begin
              state_d = ST_ISSUE;
              first_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q <= DELTA_W'(1)) begin
            state_d = ST_ISSUE;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q - DELTA_W'(1);
          end
        end
        ST_ISSUE: begin
          // A stalled issue counts as late once, on its first ISSUE cycle only.
          if (mon_ready) begin
            mon_new_input_d = 1'b1;
            mon_input_d     = data_q;
            gap_d           = GAP_W'(MIN_GAP);
            state_d         = ST_GAP;
          end else if (first_q && (late_count != '1)) begin
            late_d = late_count + LATE_W'(1);
          end
        end
        ST_GAP: begin
          // The first GAP cycle clears the pulse, so GAP always lasts at least one cycle.
          mon_new_input_d = 1'b0;
          mon_input_d     = '0;
          if (gap_q <= GAP_W'(1)) state_d = ST_IDLE;
          else                    gap_d   = gap_q - GAP_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      data_q        <= '0;
      first_q       <= 1'b0;
      mon_input     <= '0;
      mon_new_input <= 1'b0;
      late_count    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      data_q        <= data_d;
      first_q       <= first_d;
      mon_input     <= mon_input_d;
      mon_new_input <= mon_new_input_d;
      late_count    <= late_d;
    end
  end

endmodule

// File: tb/tb_monitor_event_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-level model.
module tb_monitor_event_scheduler;
  import monitor_sched_pkg::*;

  localparam int unsigned DATA_W  = DATA_W_DEF;
  localparam int unsigned DELTA_W = DELTA_W_DEF;
  localparam int unsigned DEPTH   = DEPTH_DEF;
  localparam int unsigned MIN_GAP = MIN_GAP_DEF;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam longint      G       = (MIN_GAP == 0) ? 1 : longint'(MIN_GAP);

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     en = 1'b0;
  logic                     ev_valid = 1'b0;
  logic                     ev_ready;
  logic signed [DATA_W-1:0] ev_data = '0;
  logic [DELTA_W-1:0]       ev_delta = '0;
  logic signed [DATA_W-1:0] mon_input;
  logic                     mon_new_input;
  logic                     mon_ready = 1'b1;
  logic [CW-1:0]            fifo_count;
  logic                     busy;
  logic [LATE_W-1:0]        late_count;

  monitor_event_scheduler #(
    .DATA_W  (DATA_W),
    .DELTA_W (DELTA_W),
    .DEPTH   (DEPTH),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_data       (ev_data),
    .ev_delta      (ev_delta),
    .mon_input     (mon_input),
    .mon_new_input (mon_new_input),
    .mon_ready     (mon_ready),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .late_count    (late_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queued events, the in-flight event's earliest issue edge, and when the scheduler is next free.
  sched_event_t       q[$];
  longint             n_edge = 0;
  longint             idle_from = -1;
  longint             eligible = 0;
  bit                 in_flight = 1'b0;
  logic [DATA_W-1:0]  fl_data = '0;
  bit                 exp_new = 1'b0;
  bit                 exp_busy = 1'b0;
  logic [DATA_W-1:0]  exp_in = '0;
  int                 late_m = 0;

  int                 cyc = 0;
  int                 last_pulse_cyc = -1;
  logic [DATA_W-1:0]  last_pulse_data = '0;
  int                 busy_fall_cyc = -1;
  int                 last_pop_cyc = -1;
  int                 prev_cnt = 0;
  int                 max_count = 0;
  bit                 last_rdy_obs = 1'b0;
  int                 pulses[$];
  logic [DATA_W-1:0]  pulse_vals[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_flight = 1'b0;
    idle_from = n_edge - 1;
    exp_new   = 1'b0;
    exp_busy  = 1'b0;
    exp_in    = '0;
    late_m    = 0;
  endtask

  // One enabled clock edge: issue, then pop, then push, as seen by the scheduler.
  task automatic model_edge(input bit acc, input sched_event_t ev, input bit mr);
    sched_event_t head;
    exp_new = 1'b0;
    exp_in  = '0;
    if (in_flight && n_edge >= eligible) begin
      if (mr) begin
        exp_new   = 1'b1;
        exp_in    = fl_data;
        in_flight = 1'b0;
        idle_from = n_edge + G;
      end else if (n_edge == eligible && late_m < 65535) begin
        late_m++;
      end
    end
    if (!in_flight && n_edge > idle_from && q.size() != 0) begin
      head      = q.pop_front();
      in_flight = 1'b1;
      fl_data   = head.data;
      eligible  = n_edge + longint'(head.delta) + 1;
    end
    if (acc) q.push_back(ev);
    exp_busy = in_flight || (n_edge < idle_from) || (q.size() != 0);
    n_edge++;
  endtask

  // One clock: drive at negedge, predict the edge, check outputs at the next negedge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input logic [DELTA_W-1:0] dl,
                       input bit e, input bit mr);
    bit           exp_rdy;
    bit           acc;
    bit           prev_busy;
    sched_event_t ev;
    en       = e;
    ev_valid = v;
    ev_data  = d;
    ev_delta = dl;
    mon_ready = mr;
    #1;
    exp_rdy = e && (q.size() < int'(DEPTH));
    chk("ev_ready", 64'(ev_ready), 64'(exp_rdy));
    last_rdy_obs = ev_ready;
    acc       = v && exp_rdy;
    ev.data   = d;
    ev.delta  = dl;
    prev_busy = busy;
    @(posedge clk);
    if (e) model_edge(acc, ev, mr);
    @(negedge clk);
    cyc++;
    chk("mon_new_input", 64'(mon_new_input), 64'(exp_new));
    chk("mon_input", mon_input, exp_in);
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("late_count", 64'(late_count), 64'(late_m));
    if (mon_new_input) begin
      last_pulse_cyc  = cyc;
      last_pulse_data = mon_input;
      pulses.push_back(cyc);
      pulse_vals.push_back(mon_input);
    end
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    if (int'(fifo_count) < prev_cnt) last_pop_cyc = cyc;
    prev_cnt = int'(fifo_count);
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic push_ev(input logic [DATA_W-1:0] d, input logic [DELTA_W-1:0] dl);
    cycle(1'b1, d, dl, 1'b1, 1'b1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic do_reset(input int hold);
    ev_valid = 1'b0;
    en       = 1'b1;
    rst      = 1'b0;
    #1;
    chk("rst_mon_new_input", 64'(mon_new_input), 64'd0);
    chk("rst_mon_input", mon_input, 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_late_count", 64'(late_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ev_ready", 64'(ev_ready), 64'd1);
    model_reset();
    prev_cnt = 0;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int c0;
    int acc_cyc;
    bit acc_found;

    @(negedge clk);
    do_reset(2);
    idle(3);

    // Single event, delta 0.
    pulses.delete();
    push_ev(64'd1, 32'd0);
    c0 = cyc;
    idle(5);
    chk("single_latency", 64'(last_pulse_cyc - c0), 64'd2);
    chk("single_data", last_pulse_data, 64'd1);
    chk("single_pulses", 64'(pulses.size()), 64'd1);

    // Delta 6: pulse after E8, busy drops once the gap is over.
    pulses.delete();
    busy_fall_cyc = -1;
    push_ev(64'd2, 32'd6);
    c0 = cyc;
    idle(14);
    chk("delta_latency", 64'(last_pulse_cyc - c0), 64'd8);
    chk("delta_data", last_pulse_data, 64'd2);
    chk("delta_busy_fall", 64'(busy_fall_cyc - c0), 64'd9);

    // Burst of four delta-0 events: pulses three cycles apart, in order.
    pulses.delete();
    pulse_vals.delete();
    push_ev(64'd6, 32'd0);
    c0 = cyc;
    push_ev(64'd7, 32'd0);
    push_ev(64'd8, 32'd0);
    push_ev(64'd9, 32'd0);
    idle(15);
    chk("burst_pulses", 64'(pulses.size()), 64'd4);
    for (int i = 0; i < 4 && i < pulses.size(); i++) begin
      chk("burst_time", 64'(pulses[i] - c0), 64'(2 + 3 * i));
      chk("burst_data", pulse_vals[i], 64'(6 + i));
    end

    // Backpressure: monitor not ready for five ISSUE cycles.
    pulses.delete();
    push_ev(64'd5, 32'd0);
    c0 = cyc;
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle(6);
    chk("late_latency", 64'(last_pulse_cyc - c0), 64'd7);
    chk("late_data", last_pulse_data, 64'd5);
    chk("late_count_one", 64'(late_count), 64'd1);

    // Reset in the middle of WAIT: nothing is issued afterwards.
    push_ev(64'd11, 32'd10);
    idle(4);
    do_reset(2);
    pulses.delete();
    idle(20);
    chk("rst_wait_no_pulse", 64'(pulses.size()), 64'd0);

    // Full FIFO: a blocker occupies the scheduler while nine long events are offered.
    max_count    = 0;
    last_pop_cyc = -1;
    push_ev(64'd100, 32'd20);
    for (int i = 0; i < 8; i++) push_ev(64'(200 + i), 32'd1000);
    chk("full_count", 64'(fifo_count), 64'd8);
    acc_found = 1'b0;
    acc_cyc   = -1;
    for (int k = 0; k < 100 && !acc_found; k++) begin
      cycle(1'b1, 64'd300, 32'd1000, 1'b1, 1'b1);
      if (last_rdy_obs) begin
        acc_found = 1'b1;
        acc_cyc   = cyc;
      end
    end
    chk("full_9th_accepted", 64'(acc_found), 64'd1);
    chk("full_9th_after_pop", 64'(acc_cyc - last_pop_cyc), 64'd1);
    idle(3);
    chk("full_max_count", 64'(max_count), 64'd8);

    // Reset with events still pending.
    do_reset(3);
    pulses.delete();
    idle(10);
    chk("rst_pending_no_pulse", 64'(pulses.size()), 64'd0);

    // Random traffic with enable and backpressure toggling.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 40,
            {$urandom, $urandom},
            DELTA_W'($urandom_range(0, 6)),
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) > 2);
    end
    idle(200);
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
